ili9341_spi_tx: RTL and testbench

ILI9341_SPI_TX -- requirements
Module: ili9341_spi_tx

---
 rtl/ili9341_spi_tx.sv | 189 ++++++++++++++++++
 tb/tb_ili9341_spi_tx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ili9341_spi_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ili9341_spi_tx
//  Purpose  : Byte-wide SPI mode-0 transmitter for an ILI9341 panel. Accepts
//             bytes on a valid/ready handshake, frames them with chip select,
//             shifts MSB first and presents the data/command flag alongside.
//             Back-to-back bytes are streamed without releasing chip select.
//  Ports    : clk, rst_n (async, active-low)
//             i_valid / o_ready / i_data[7:0] / i_dc   upstream byte handshake
//             display_csb, spi_clk, spi_mosi, data_commandb   panel side
//             spi_miso   panel read-back (used only with SPI_RX_EN)
//             o_busy     high while a transfer is in progress
//             o_rx_valid, o_rx_data[7:0]   only with SPI_RX_EN defined
//  Options  : `define SPI_RX_EN to add the MISO receive shift register.
//  Revision : 1.0  initial release
// ============================================================================
module ili9341_spi_tx #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [7:0] i_data,
  input  logic       i_dc,
  output logic       display_csb,
  output logic       spi_clk,
  output logic       spi_mosi,
  output logic       data_commandb,
  input  logic       spi_miso,
  output logic       o_busy
`ifdef SPI_RX_EN
  ,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_data
`endif
);

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CS_SETUP = 2'd1,
    SHIFT    = 2'd2,
    CS_HOLD  = 2'd3
  } state_t;

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_n;
  logic       phase, phase_n;       // 0 = SPI clock low phase, 1 = high phase
  logic [7:0] tx_byte, byte_n;
  logic       dc_q, dc_n;
  logic       ready_en;             // holds o_ready low until the first edge after reset
  logic       cnt_done;
  logic       last_hi;              // final clk of the bit-0 high phase
  logic       accept;

  assign cnt_done = (cnt == DIV_M1);
  assign last_hi  = (state == SHIFT) && phase && (bit_idx == 3'd0) && cnt_done;
  assign o_ready  = ready_en && ((state == IDLE) || last_hi);
  assign accept   = i_valid && o_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      bit_idx <= 3'd0;
      phase   <= 1'b0;
      tx_byte <= 8'd0;
      dc_q    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      phase   <= phase_n;
      tx_byte <= byte_n;
      dc_q    <= dc_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    phase_n = phase;
    byte_n  = tx_byte;
    dc_n    = dc_q;
    case (state)
      IDLE: begin
        cnt_n   = 8'd0;
        phase_n = 1'b0;
        if (accept) begin
          byte_n  = i_data;
          dc_n    = i_dc;
          bit_n   = 3'd7;       // bit 7 must be on MOSI during chip-select setup
          state_n = CS_SETUP;
        end
      end
      CS_SETUP: begin
        if (cnt_done) begin
          cnt_n   = 8'd0;
          phase_n = 1'b0;
          bit_n   = 3'd7;
          state_n = SHIFT;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      SHIFT: begin
        if (!cnt_done) begin
          cnt_n = cnt + 8'd1;
        end else begin
          cnt_n = 8'd0;
          if (!phase) begin
            phase_n = 1'b1;
          end else if (bit_idx != 3'd0) begin
            phase_n = 1'b0;
            bit_n   = bit_idx - 3'd1;
          end else if (accept) begin
            // Burst: next byte's bit 7 low phase follows directly, CS stays low.
            phase_n = 1'b0;
            bit_n   = 3'd7;
            byte_n  = i_data;
            dc_n    = i_dc;
          end else begin
            phase_n = 1'b0;
            state_n = CS_HOLD;
          end
        end
      end
      CS_HOLD: begin
        if (cnt_done) begin
          cnt_n   = 8'd0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 8'd0;
        phase_n = 1'b0;
      end
    endcase
  end

  assign display_csb   = (state == IDLE);
  assign spi_clk       = (state == SHIFT) && phase;
  // bit_idx only moves at the end of a high phase, so MOSI changes only while spi_clk is low.
  assign spi_mosi      = (state != IDLE) && tx_byte[bit_idx];
  assign data_commandb = dc_q;
  assign o_busy        = (state != IDLE);

`ifdef SPI_RX_EN
  logic [7:0] rx_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sh      <= 8'd0;
      o_rx_valid <= 1'b0;
      o_rx_data  <= 8'd0;
    end else begin
      o_rx_valid <= 1'b0;
      // Sample on the edge where spi_clk goes high (end of the low phase).
      if ((state == SHIFT) && !phase && cnt_done) begin
        rx_sh <= {rx_sh[6:0], spi_miso};
      end
      if (last_hi) begin
        o_rx_valid <= 1'b1;
        o_rx_data  <= rx_sh;
      end
    end
  end
`else
  logic unused_miso;
  assign unused_miso = spi_miso;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ili9341_spi_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ili9341_spi_tx
//  Purpose  : Self-checking bench for ili9341_spi_tx. One instance with the
//             default divider (2) runs a vector table of single bytes plus
//             burst and mid-transfer reset sequences; a second instance with
//             CLK_DIV=1 runs a single-byte sequence.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ili9341_spi_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: CLK_DIV = 2
  logic       i_valid = 1'b0;
  logic [7:0] i_data  = 8'd0;
  logic       i_dc    = 1'b0;
  logic       ready0, csb0, sclk0, mosi0, dcb0, busy0;
  logic       miso    = 1'b0;

  ili9341_spi_tx #(.CLK_DIV(2)) dut0 (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_valid       (i_valid),
    .o_ready       (ready0),
    .i_data        (i_data),
    .i_dc          (i_dc),
    .display_csb   (csb0),
    .spi_clk       (sclk0),
    .spi_mosi      (mosi0),
    .data_commandb (dcb0),
    .spi_miso      (miso),
    .o_busy        (busy0)
  );

  // Instance 1: CLK_DIV = 1
  logic       valid1 = 1'b0;
  logic [7:0] data1  = 8'd0;
  logic       dc1    = 1'b0;
  logic       ready1, csb1, sclk1, mosi1, dcb1, busy1;

  ili9341_spi_tx #(.CLK_DIV(1)) dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_valid       (valid1),
    .o_ready       (ready1),
    .i_data        (data1),
    .i_dc          (dc1),
    .display_csb   (csb1),
    .spi_clk       (sclk1),
    .spi_mosi      (mosi1),
    .data_commandb (dcb1),
    .spi_miso      (miso),
    .o_busy        (busy1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor for instance 0, sampled on the falling edge.
  int          edges, low_cycles, ready_pulses, busy_bad, csb_rises, first_ready_edge;
  logic [15:0] bits, dcs;
  logic        prev_sclk = 1'b0;
  logic        prev_csb  = 1'b1;

  task automatic clear_mon();
    edges = 0; low_cycles = 0; ready_pulses = 0; busy_bad = 0; csb_rises = 0;
    first_ready_edge = -1; bits = 16'd0; dcs = 16'd0;
  endtask

  always @(negedge clk) begin
    if (!csb0) low_cycles++;
    if (sclk0 && !prev_sclk) begin
      bits = {bits[14:0], mosi0};
      dcs  = {dcs[14:0], dcb0};
      edges++;
    end
    if (!csb0 && ready0) begin
      if (ready_pulses == 0) first_ready_edge = edges;
      ready_pulses++;
    end
    if (busy0 == csb0) busy_bad++;
    if (csb0 && !prev_csb) csb_rises++;
    prev_sclk = sclk0;
    prev_csb  = csb0;
  end

  // Drive one byte into instance 0 and wait for chip select to be released.
  task automatic send_one(input logic [7:0] d, input logic dc, input bit noise);
    int g;
    g = 0;
    while (!ready0 && g < 100) begin @(posedge clk); #1; g++; end
    check("ready_before_send", 32'(ready0), 1);
    clear_mon();
    i_valid = 1'b1; i_data = d; i_dc = dc;
    @(posedge clk); #1;
    i_valid = 1'b0;
    g = 0;
    while (csb_rises == 0 && g < 400) begin
      if (noise) begin
        i_data  = 8'($urandom);
        i_dc    = 1'($urandom);
        i_valid = ready0 ? 1'b0 : 1'($urandom);
      end
      @(posedge clk); #1; g++;
    end
    i_valid = 1'b0;
    check("csb_release_seen", csb_rises, 1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       dc;
    bit         noise;
    logic [7:0] exp_bits;
    int         exp_low;
    int         exp_edges;
    int         exp_ready;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int g;
    int low1, e1, hi1;
    logic [7:0] b1;
    logic ps;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 36, 8, 1};
    vecs[1] = '{8'h11, 1'b1, 1'b1, 8'h11, 36, 8, 1};
    vecs[2] = '{8'h00, 1'b1, 1'b0, 8'h00, 36, 8, 1};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 36, 8, 1};
    vecs[4] = '{8'h80, 1'b1, 1'b0, 8'h80, 36, 8, 1};
    vecs[5] = '{8'h01, 1'b0, 1'b1, 8'h01, 36, 8, 1};
    clear_mon();

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_csb",   32'(csb0),  1);
    check("rst_sclk",  32'(sclk0), 0);
    check("rst_mosi",  32'(mosi0), 0);
    check("rst_dcb",   32'(dcb0),  0);
    check("rst_busy",  32'(busy0), 0);
    check("rst_ready", 32'(ready0), 0);
    rst_n = 1'b1;
    #2;
    check("ready_low_before_edge", 32'(ready0), 0);
    @(posedge clk); #1;
    check("ready_after_first_edge", 32'(ready0), 1);

    // Single-byte vector table
    for (int i = 0; i < 6; i++) begin
      send_one(vecs[i].data, vecs[i].dc, vecs[i].noise);
      check($sformatf("v%0d_bits", i),   32'(bits[7:0]), 32'(vecs[i].exp_bits));
      check($sformatf("v%0d_edges", i),  edges, vecs[i].exp_edges);
      check($sformatf("v%0d_csb_low", i), low_cycles, vecs[i].exp_low);
      check($sformatf("v%0d_dcb", i),    32'(dcs[7:0]), vecs[i].dc ? 32'hFF : 32'h00);
      check($sformatf("v%0d_busy_vs_csb", i), busy_bad, 0);
      check($sformatf("v%0d_ready_pulses", i), ready_pulses, vecs[i].exp_ready);
      @(posedge clk); #1;
    end

    // Burst: 2C (command) then FF (data) with valid held
    g = 0;
    while (!ready0 && g < 100) begin @(posedge clk); #1; g++; end
    clear_mon();
    i_valid = 1'b1; i_data = 8'h2C; i_dc = 1'b0;
    @(posedge clk); #1;
    i_data = 8'hFF; i_dc = 1'b1;
    g = 0;
    while (!ready0 && g < 200) begin @(posedge clk); #1; g++; end
    @(posedge clk); #1;
    i_valid = 1'b0;
    g = 0;
    while (csb_rises == 0 && g < 400) begin @(posedge clk); #1; g++; end
    check("burst_edges",        edges, 16);
    check("burst_bits",         32'(bits), 32'h2CFF);
    check("burst_csb_low",      low_cycles, 68);
    check("burst_csb_rises",    csb_rises, 1);
    check("burst_dcb_per_edge", 32'(dcs), 32'h00FF);
    check("burst_first_ready_at_edge", first_ready_edge, 8);
    check("burst_ready_pulses", ready_pulses, 2);
    check("burst_busy_vs_csb",  busy_bad, 0);
    @(posedge clk); #1;

    // Reset in the middle of a byte
    clear_mon();
    i_valid = 1'b1; i_data = 8'hC3; i_dc = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    g = 0;
    while (edges < 4 && g < 200) begin @(posedge clk); #1; g++; end
    check("midrst_first_bits", 32'(bits[3:0]), 32'hC);
    rst_n = 1'b0;
    #1;
    check("midrst_csb",   32'(csb0),   1);
    check("midrst_sclk",  32'(sclk0),  0);
    check("midrst_mosi",  32'(mosi0),  0);
    check("midrst_dcb",   32'(dcb0),   0);
    check("midrst_busy",  32'(busy0),  0);
    check("midrst_ready", 32'(ready0), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #2;
    check("midrst_ready_held", 32'(ready0), 0);
    check("midrst_no_trailing_edge", edges, 4);
    @(posedge clk); #1;
    check("midrst_ready_back", 32'(ready0), 1);
    send_one(8'h3C, 1'b0, 1'b0);
    check("post_rst_bits",    32'(bits[7:0]), 32'h3C);
    check("post_rst_edges",   edges, 8);
    check("post_rst_csb_low", low_cycles, 36);

    // CLK_DIV = 1 instance, byte 0x80
    g = 0;
    while (!ready1 && g < 50) begin @(posedge clk); #1; g++; end
    valid1 = 1'b1; data1 = 8'h80; dc1 = 1'b1;
    @(posedge clk); #1;
    valid1 = 1'b0;
    low1 = 0; e1 = 0; hi1 = 0; b1 = 8'd0; ps = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!csb1) low1++;
      if (mosi1) hi1++;
      if (sclk1 && !ps) begin e1++; b1 = {b1[6:0], mosi1}; end
      ps = sclk1;
      @(posedge clk); #1;
    end
    check("div1_csb_low",    low1, 18);
    check("div1_edges",      e1, 8);
    check("div1_bits",       32'(b1), 32'h80);
    check("div1_mosi_high",  hi1, 3);
    check("div1_dcb",        32'(dcb1), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
